// File: rtl/nand_seq_pkg.sv
// Shared definitions for the bit-serial Nand sequencer: sequencer states,
// default sizing and a small modular-wrap helper used by the round-robin logic.
package nand_seq_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // Wrap an index that may exceed the requester count by less than one lap.
  function automatic int rr_wrap(input int idx, input int n);
    if (idx >= n) begin
      return idx - n;
    end else begin
      return idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// above the pointer, wrapping past the top requester back to requester 0.
module rr_arbiter
  import nand_seq_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx,
  output logic             grant_valid
);

  // Scan offsets 0..N_REQ-1 from the pointer; the first hit wins.
  always_comb begin
    grant       = {N_REQ{1'b0}};
    grant_idx   = {IDW{1'b0}};
    grant_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!grant_valid && req[j] && (j == rr_wrap(int'(ptr) + k, N_REQ))) begin
          grant_valid = 1'b1;
          grant[j]    = 1'b1;
          grant_idx   = IDW'(j);
        end else begin
          grant_valid = grant_valid;
        end
      end
    end
  end

endmodule

// File: rtl/nand_serial_sequencer.sv
// Bit-serial sequencer sharing one external 1-bit Nand cell among N_REQ
// requesters. One operand pair is accepted at a time, streamed LSB-first
// through the cell, and the WIDTH-bit NAND result is reassembled.
module nand_serial_sequencer
  import nand_seq_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       ack,
  output logic                   nand_a,
  output logic                   nand_b,
  input  logic                   nand_res,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       result,
  output logic [IDW-1:0]         result_id
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state_r;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   grant_id_r;
  logic [WIDTH-1:0] sh_a_r;
  logic [WIDTH-1:0] sh_b_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic [N_REQ-1:0] ack_r;
  logic             nand_a_r;
  logic             nand_b_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic [IDW-1:0]   result_id_r;

  logic [N_REQ-1:0] grant_s;
  logic [IDW-1:0]   grant_idx_s;
  logic             grant_valid_s;
  logic [IDW-1:0]   ptr_next_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [WIDTH-1:0] acc_next_s;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req         (req),
    .ptr         (ptr_r),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Priority moves to the requester just above the one being served.
  assign ptr_next_s = IDW'(rr_wrap(int'(grant_idx_s) + 1, N_REQ));

  // The Nand output for the bit currently on nand_a/nand_b enters at the MSB.
  assign acc_next_s = {nand_res, acc_r[WIDTH-1:1]};

  // Route the granted requester's operand slices to the capture registers.
  always_comb begin
    sel_a_s = {WIDTH{1'b0}};
    sel_b_s = {WIDTH{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx_s == IDW'(i)) begin
        sel_a_s = req_a[i*WIDTH +: WIDTH];
        sel_b_s = req_b[i*WIDTH +: WIDTH];
      end else begin
        sel_a_s = sel_a_s;
        sel_b_s = sel_b_s;
      end
    end
  end

  // Sequencer FSM with all outputs registered; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {IDW{1'b0}};
      grant_id_r  <= {IDW{1'b0}};
      sh_a_r      <= {WIDTH{1'b0}};
      sh_b_r      <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      ack_r       <= {N_REQ{1'b0}};
      nand_a_r    <= 1'b0;
      nand_b_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      result_id_r <= {IDW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r   <= 1'b0;
          nand_a_r <= 1'b0;
          nand_b_r <= 1'b0;
          if (grant_valid_s) begin
            sh_a_r     <= sel_a_s;
            sh_b_r     <= sel_b_s;
            grant_id_r <= grant_idx_s;
            ptr_r      <= ptr_next_s;
            ack_r      <= grant_s;
            busy_r     <= 1'b1;
            state_r    <= ST_LOAD;
          end else begin
            ack_r   <= {N_REQ{1'b0}};
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          // Present bit 0 to the cell so RUN starts with valid data.
          ack_r    <= {N_REQ{1'b0}};
          cnt_r    <= {CW{1'b0}};
          nand_a_r <= sh_a_r[0];
          nand_b_r <= sh_b_r[0];
          sh_a_r   <= {1'b0, sh_a_r[WIDTH-1:1]};
          sh_b_r   <= {1'b0, sh_b_r[WIDTH-1:1]};
          state_r  <= ST_RUN;
        end
        ST_RUN: begin
          acc_r <= acc_next_s;
          if (cnt_r == CW'(WIDTH - 1)) begin
            result_r    <= acc_next_s;
            result_id_r <= grant_id_r;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            nand_a_r    <= 1'b0;
            nand_b_r    <= 1'b0;
            state_r     <= ST_DONE;
          end else begin
            nand_a_r <= sh_a_r[0];
            nand_b_r <= sh_b_r[0];
            sh_a_r   <= {1'b0, sh_a_r[WIDTH-1:1]};
            sh_b_r   <= {1'b0, sh_b_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + CW'(1);
            state_r  <= ST_RUN;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ack_r    <= {N_REQ{1'b0}};
          nand_a_r <= 1'b0;
          nand_b_r <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_r;
  assign nand_a    = nand_a_r;
  assign nand_b    = nand_b_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign result_id = result_id_r;

endmodule
